// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Holds the default sample width, complex word, bank state and bit reversal.
package fft_pkg;

    localparam int FFT_DATA_WIDTH = 16;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] real_part;
        logic signed [FFT_DATA_WIDTH-1:0] imag_part;
    } complex_t;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    // Reverse the low 'width' bits of idx; higher bits come back zero.
    function automatic logic [31:0] bitrev(
        input logic [31:0] idx,
        input int          width
    );
        logic [31:0] src;
        logic [31:0] r;
        src = idx;
        r   = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r   = {r[30:0], src[0]};
                src = src >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N_POINTS-entry complex register file: sync write, async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int N_POINTS   = 8,
    localparam int AW        = $clog2(N_POINTS)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [2*DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]           raddr,
    output logic [2*DATA_WIDTH-1:0] rdata
);

    logic [2*DATA_WIDTH-1:0] mem [N_POINTS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT stream in, natural order out.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_real/in_imag;
// out_valid/out_ready/out_real/out_imag/out_index/out_last.
// Macro FFT_REORDER_SCALE_EN enables rounded 1/N scaling at the output.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int N_POINTS   = 8,
    localparam int LOG2N     = $clog2(N_POINTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_real,
    output logic signed [DATA_WIDTH-1:0] out_imag,
    output logic [LOG2N-1:0]             out_index,
    output logic                         out_last
);

    localparam int W2 = 2 * DATA_WIDTH;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

`ifdef FFT_REORDER_SCALE_EN
    localparam logic signed [DATA_WIDTH:0] RND =
        (DATA_WIDTH + 1)'(1) << (LOG2N - 1);

    // One guard bit keeps the rounding add from wrapping.
    function automatic logic [DATA_WIDTH-1:0] norm(
        input logic [DATA_WIDTH-1:0] x
    );
        logic signed [DATA_WIDTH:0] s;
        s = $signed({x[DATA_WIDTH-1], x}) + RND;
        return DATA_WIDTH'(s >>> LOG2N);
    endfunction
`else
    function automatic logic [DATA_WIDTH-1:0] norm(
        input logic [DATA_WIDTH-1:0] x
    );
        return x;
    endfunction
`endif

    bank_state_e      state [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] wr_addr;
    logic [W2-1:0]    rd_data [2];
    logic [W2-1:0]    rd_word;
    logic             in_fire;
    logic             rd_load;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready = !rst && (state[wr_bank] == BANK_EMPTY);
    assign in_fire  = in_valid && in_ready;
    assign rd_load  = (state[rd_bank] == BANK_FULL)
                   && (!out_valid || out_ready);

    // Scatter on write so the read side walks addresses linearly.
    assign wr_addr = LOG2N'(bitrev(32'(wr_cnt), LOG2N));
    assign rd_word = rd_data[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .N_POINTS   (N_POINTS)
        ) u_bank (
            .clk   (clk),
            .we    (in_fire && (wr_bank == 1'(b))),
            .waddr (wr_addr),
            .wdata ({in_real, in_imag}),
            .raddr (rd_cnt),
            .rdata (rd_data[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state[0]  <= BANK_EMPTY;
            state[1]  <= BANK_EMPTY;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire) begin
                wr_cnt <= wr_cnt + ONE;
                if (wr_cnt == LAST) begin
                    state[wr_bank] <= BANK_FULL;
                    wr_bank        <= ~wr_bank;
                end
            end
            // Write and read banks differ whenever both fire.
            if (rd_load) begin
                out_real  <= norm(rd_word[W2-1:DATA_WIDTH]);
                out_imag  <= norm(rd_word[DATA_WIDTH-1:0]);
                out_index <= rd_cnt;
                out_last  <= (rd_cnt == LAST);
                out_valid <= 1'b1;
                rd_cnt    <= rd_cnt + ONE;
                if (rd_cnt == LAST) begin
                    state[rd_bank] <= BANK_EMPTY;
                    rd_bank        <= ~rd_bank;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed self-checking bench for fft_bitrev_reorder (N_POINTS=8).
// Scenario tasks run in sequence; summary line at the end.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_real;
    logic signed [15:0] in_imag;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_real;
    logic signed [15:0] out_imag;
    logic [2:0]         out_index;
    logic               out_last;

    int tests = 0;
    int fails = 0;
    int br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_reorder #(
        .DATA_WIDTH (16),
        .N_POINTS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_index (out_index),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive input position p of a run whose frame f has value base f.
    task automatic drive(input int p, input int n, input int b0,
                         input int b1, input int b2);
        int v;
        int bs [3];
        bs = '{b0, b1, b2};
        in_valid = (p < n);
        if (p < n) begin
            v = bs[p / 8] + br_tab[p % 8];
            in_real = 16'(v);
            in_imag = 16'(-v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_real = '0;
        in_imag = '0;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags in_ready=%b out_valid=%b want 0 0",
                     in_ready, out_valid);
        end
        tests++;
        if (out_real !== 16'sd0 || out_imag !== 16'sd0 ||
            out_index !== 3'd0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_out re=%0d im=%0d idx=%0d last=%b want 0",
                     out_real, out_imag, out_index, out_last);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_single_frame();
        out_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            drive(p, 8, 0, 0, 0);
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL single_in_ready p=%0d got %b want 1",
                         p, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_latency out_valid=%b want 0", out_valid);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_real !== 16'(k) ||
                out_imag !== 16'(-k) || out_index !== 3'(k) ||
                out_last !== (k == 7)) begin
                fails++;
                $display("FAIL single_out k=%0d v=%b re=%0d im=%0d idx=%0d last=%b want 1 %0d %0d %0d %b",
                         k, out_valid, out_real, out_imag, out_index,
                         out_last, k, -k, k, k == 7);
            end
            tick();
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_idle out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        int p = 0;
        int n = 0;
        int bs [3] = '{100, 200, 300};
        int v;
        bit started = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && n < 24; c++) begin
            drive(p, 24, 100, 200, 300);
            if (p < 24) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_in_ready c=%0d got %b want 1",
                             c, in_ready);
                end
            end
            if (started) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_bubble n=%0d out_valid=%b want 1",
                             n, out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                started = 1'b1;
                v = bs[n / 8] + n % 8;
                tests++;
                if (out_real !== 16'(v) || out_imag !== 16'(-v) ||
                    out_index !== 3'(n % 8) ||
                    out_last !== (n % 8 == 7)) begin
                    fails++;
                    $display("FAIL stream_out n=%0d re=%0d im=%0d idx=%0d last=%b want %0d %0d %0d",
                             n, out_real, out_imag, out_index, out_last,
                             v, -v, n % 8);
                end
                n++;
            end
            if (in_valid && in_ready) p++;
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (n != 24) begin
            fails++;
            $display("FAIL stream_count got %0d want 24", n);
        end
    endtask

    task automatic test_backpressure();
        int p = 0;
        int n = 0;
        int hold = 0;
        int bs [3] = '{500, 600, 700};
        int v;
        out_ready = 1'b0;
        for (int c = 0; c < 60 && hold < 4; c++) begin
            drive(p, 24, 500, 600, 700);
            if (p >= 16) begin
                hold++;
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_full_ready got %b want 0", in_ready);
                end
                tests++;
                if (out_valid !== 1'b1 || out_index !== 3'd0 ||
                    out_real !== 16'sd500) begin
                    fails++;
                    $display("FAIL bp_stall_out v=%b idx=%0d re=%0d want 1 0 500",
                             out_valid, out_index, out_real);
                end
            end
            if (in_valid && in_ready) p++;
            tick();
        end
        tests++;
        if (p != 16) begin
            fails++;
            $display("FAIL bp_accepts got %0d want 16", p);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 80 && n < 24; c++) begin
            drive(p, 24, 500, 600, 700);
            if (out_valid === 1'b1) begin
                v = bs[n / 8] + n % 8;
                tests++;
                if (out_real !== 16'(v) || out_imag !== 16'(-v) ||
                    out_index !== 3'(n % 8)) begin
                    fails++;
                    $display("FAIL bp_out n=%0d re=%0d im=%0d idx=%0d want %0d %0d %0d",
                             n, out_real, out_imag, out_index, v, -v, n % 8);
                end
                if (n < 8) begin
                    tests++;
                    if (in_ready !== (n == 7)) begin
                        fails++;
                        $display("FAIL bp_release n=%0d in_ready=%b want %b",
                                 n, in_ready, n == 7);
                    end
                end
                n++;
            end
            if (in_valid && in_ready) p++;
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (n != 24 || p != 24) begin
            fails++;
            $display("FAIL bp_count out=%0d in=%0d want 24 24", n, p);
        end
    endtask

    task automatic test_toggle();
        int p = 0;
        int n = 0;
        int bs [3] = '{40, 60, 0};
        int v;
        bit prev_stall = 1'b0;
        logic signed [15:0] pr;
        logic signed [15:0] pi;
        logic [2:0] px;
        pr = '0;
        pi = '0;
        px = '0;
        for (int c = 0; c < 100 && n < 16; c++) begin
            out_ready = (c % 2 == 0);
            drive(p, 16, 40, 60, 0);
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_real !== pr ||
                    out_imag !== pi || out_index !== px) begin
                    fails++;
                    $display("FAIL toggle_hold v=%b re=%0d im=%0d idx=%0d want 1 %0d %0d %0d",
                             out_valid, out_real, out_imag, out_index,
                             pr, pi, px);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                v = bs[n / 8] + n % 8;
                tests++;
                if (out_real !== 16'(v) || out_imag !== 16'(-v) ||
                    out_index !== 3'(n % 8)) begin
                    fails++;
                    $display("FAIL toggle_out n=%0d re=%0d im=%0d idx=%0d want %0d %0d %0d",
                             n, out_real, out_imag, out_index, v, -v, n % 8);
                end
                n++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            pr = out_real;
            pi = out_imag;
            px = out_index;
            if (in_valid && in_ready) p++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (n != 16 || p != 16) begin
            fails++;
            $display("FAIL toggle_count out=%0d in=%0d want 16 16", n, p);
        end
    endtask

    task automatic test_midframe_reset();
        int p = 0;
        int n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 40 && p < 13; c++) begin
            drive(p, 13, 880, 900, 0);
            if (in_valid && in_ready) p++;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
            out_index !== 3'd0) begin
            fails++;
            $display("FAIL mid_rst v=%b rdy=%b idx=%0d want 0 0 0",
                     out_valid, in_ready, out_index);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_after v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        p = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            drive(p, 8, 20, 0, 0);
            if (out_valid === 1'b1) begin
                tests++;
                if (out_real !== 16'(20 + n) || out_imag !== 16'(-(20 + n)) ||
                    out_index !== 3'(n)) begin
                    fails++;
                    $display("FAIL mid_out n=%0d re=%0d im=%0d idx=%0d want %0d %0d %0d",
                             n, out_real, out_imag, out_index,
                             20 + n, -(20 + n), n);
                end
                n++;
            end
            if (in_valid && in_ready) p++;
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL mid_count got %0d want 8", n);
        end
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_extra c=%0d out_valid=%b want 0",
                         c, out_valid);
            end
            tick();
        end
    endtask

`ifdef FFT_REORDER_SCALE_EN
    task automatic test_scale();
        int nat [8] = '{800, -8, 4, -4, 3, -5, 0, 7};
        int exp_v [8] = '{100, -1, 1, 0, 0, -1, 0, 1};
        complex_t w;
        out_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            w.real_part = 16'(nat[br_tab[p]]);
            w.imag_part = 16'(nat[br_tab[p]]);
            in_valid = 1'b1;
            in_real = w.real_part;
            in_imag = w.imag_part;
            tick();
        end
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_real !== 16'(exp_v[k]) ||
                out_imag !== 16'(exp_v[k]) || out_index !== 3'(k)) begin
                fails++;
                $display("FAIL scale_out k=%0d v=%b re=%0d im=%0d idx=%0d want 1 %0d %0d %0d",
                         k, out_valid, out_real, out_imag, out_index,
                         exp_v[k], exp_v[k], k);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef FFT_REORDER_SCALE_EN
        test_scale();
`else
        test_single_frame();
        test_streaming();
        test_backpressure();
        test_toggle();
        test_midframe_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
